instr_fetch: RTL and testbench

Instruction fetch unit for the 8-bit Von Neumann CPU.
- Drives the program counter's op code.
- Reads each 16-bit instruction as two bytes from the shared byte-wide memory and assembles it in an instruction register.
- Presents the instruction to decode through a valid/ready handshake.
- Sits between `pc`/`mem` (upstream) and decode/`alu` (downstream). It owns the memory port only while a fetch is in flight.

---
 rtl/cpu8_pkg.sv | 18 +
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared types and constants for the 8-bit Von Neumann CPU.
package cpu8_pkg;
   typedef enum logic [1:0] {
      PC_RESET     = 2'b00,
      PC_NOTHING   = 2'b01,
      PC_INCREMENT = 2'b10,
      PC_JUMP      = 2'b11
   } pc_op_e;
   typedef enum logic [2:0] {
      FS_PC_RST,
      FS_ADDR_HI,
      FS_ADDR_LO,
      FS_CAPT_LO,
      FS_VALID,
      FS_HALT
   } fetch_state_e;
   localparam logic [15:0] HALT_OPCODE_DEF = 16'hFFFF;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetches 16-bit instructions as two bytes and hands them to decode.
// Define IFETCH_HALT_EN to stop fetching on HALT_OPCODE.
module instr_fetch
   import cpu8_pkg::*;
#(
   parameter logic [15:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_addr,
   output logic [1:0]  pc_op,
   output logic        mem_own,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_q,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        jump_req,
   output logic        halted
);
`ifdef IFETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif
   fetch_state_e r_state, w_next;
   logic [15:0]  r_instr;
   logic [15:0]  w_addr_inc;
   logic         w_halt_hit;
   pc_op_e       w_pc_op;
   assign w_addr_inc = pc_addr + 16'd1;
   // high byte is already in the register while the low byte sits on mem_q
   assign w_halt_hit = HALT_EN && ({r_instr[15:8], mem_q} == HALT_OPCODE);
   always_comb begin
      w_next      = r_state;
      w_pc_op     = PC_NOTHING;
      mem_own     = 1'b0;
      mem_addr    = '0;
      instr_valid = 1'b0;
      case (r_state)
         FS_PC_RST: begin
            w_pc_op = PC_RESET;
            w_next  = FS_ADDR_HI;
         end
         FS_ADDR_HI: begin
            mem_own  = 1'b1;
            mem_addr = pc_addr;
            w_next   = FS_ADDR_LO;
         end
         FS_ADDR_LO: begin
            mem_own  = 1'b1;
            mem_addr = w_addr_inc;
            w_next   = FS_CAPT_LO;
         end
         FS_CAPT_LO: begin
            mem_own  = 1'b1;
            mem_addr = w_addr_inc;
            w_pc_op  = PC_INCREMENT;
            w_next   = w_halt_hit ? FS_HALT : FS_VALID;
         end
         FS_VALID: begin
            instr_valid = 1'b1;
            w_pc_op     = (instr_ready && jump_req) ? PC_JUMP : PC_NOTHING;
            w_next      = instr_ready ? FS_ADDR_HI : FS_VALID;
         end
         FS_HALT: w_next = FS_HALT;
         default: w_next = FS_PC_RST;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FS_PC_RST;
         r_instr <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == FS_ADDR_LO) r_instr[15:8] <= mem_q;
         if (r_state == FS_CAPT_LO) r_instr[7:0] <= mem_q;
      end
   end
   assign pc_op  = w_pc_op;
   assign instr  = r_instr;
   assign halted = HALT_EN && (r_state == FS_HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: drives instr_fetch with a byte memory and PC model, checks
// delivered words against the memory contents at the expected program counter.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc_addr;
   logic [1:0]  pc_op;
   logic        mem_own;
   logic [15:0] mem_addr;
   logic [7:0]  mem_q;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        jump_req = 1'b0;
   logic        halted;
   logic [7:0]  k = 8'h00;
   logic        pc_force = 1'b0;
   logic [15:0] pc_force_val = 16'h0000;
   logic [7:0]  mem [0:65535];
   logic [15:0] exp_pc;
   logic [15:0] exp_word;
   int vectors = 0;
   int miscompares = 0;

   localparam logic [1:0] OP_RESET = 2'b00, OP_NOTHING = 2'b01, OP_INC = 2'b10, OP_JUMP = 2'b11;

   instr_fetch dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_op(pc_op), .mem_own(mem_own),
      .mem_addr(mem_addr), .mem_q(mem_q), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .jump_req(jump_req), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_q <= mem[mem_addr];

   // program counter: jump offset is in instructions, relative to the incremented PC
   always @(posedge clk) begin
      if (pc_force) pc_addr <= pc_force_val;
      else case (pc_op)
         OP_RESET: pc_addr <= 16'h0000;
         OP_INC:   pc_addr <= pc_addr + 16'd2;
         OP_JUMP:  pc_addr <= pc_addr + {{7{k[7]}}, k, 1'b0};
         default:  pc_addr <= pc_addr;
      endcase
   end

   task automatic wait_valid();
      int n = 0;
      bit got = 0;
      logic [15:0] a1;
      a1 = exp_pc + 16'd1;
      exp_word = {mem[exp_pc], mem[a1]};
      while (!got && n < 12) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            vectors++;
            if (mem_own !== 1'b1 || mem_addr !== exp_pc) begin
               miscompares++;
               $display("FAIL addr_hi: own=%b addr=%h expected own=1 addr=%h", mem_own, mem_addr, exp_pc);
            end
         end
         if (n == 2) begin
            vectors++;
            if (mem_own !== 1'b1 || mem_addr !== a1) begin
               miscompares++;
               $display("FAIL addr_lo: own=%b addr=%h expected own=1 addr=%h", mem_own, mem_addr, a1);
            end
         end
         got = (instr_valid === 1'b1);
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL valid_timeout: no instr_valid within %0d cycles (pc %h)", n, exp_pc);
      end else if (n != 4 || instr !== exp_word || pc_addr !== exp_pc + 16'd2) begin
         miscompares++;
         $display("FAIL deliver: latency=%0d instr=%h pc=%h expected latency=4 instr=%h pc=%h",
                  n, instr, pc_addr, exp_word, exp_pc + 16'd2);
      end
   endtask

   task automatic deliver(input int stall, input bit j, input logic [7:0] kk,
                          input bit frc, input logic [15:0] fval);
      wait_valid();
      for (int s = 0; s < stall; s++) begin
         vectors++;
         if (instr_valid !== 1'b1 || instr !== exp_word || mem_own !== 1'b0 ||
             pc_addr !== exp_pc + 16'd2 || pc_op !== OP_NOTHING) begin
            miscompares++;
            $display("FAIL stall: valid=%b instr=%h own=%b pc=%h op=%b expected 1 %h 0 %h 01",
                     instr_valid, instr, mem_own, pc_addr, pc_op, exp_word, exp_pc + 16'd2);
         end
         @(negedge clk);
      end
      instr_ready = 1'b1;
      jump_req = j;
      k = kk;
      pc_force = frc;
      pc_force_val = fval;
      #1;
      vectors++;
      if (pc_op !== (j ? OP_JUMP : OP_NOTHING) || instr_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_op: op=%b valid=%b expected op=%b valid=1", pc_op, instr_valid,
                  j ? OP_JUMP : OP_NOTHING);
      end
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
      jump_req = 1'b0;
      pc_force = 1'b0;
      exp_pc = frc ? fval : exp_pc + 16'd2 + (j ? {{7{kk[7]}}, kk, 1'b0} : 16'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instr_ready = 1'b0;
      jump_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (instr !== 16'h0000 || instr_valid !== 1'b0 || halted !== 1'b0 || pc_op !== OP_RESET || mem_own !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: instr=%h valid=%b halted=%b op=%b own=%b expected 0000 0 0 00 0",
                  instr, instr_valid, halted, pc_op, mem_own);
      end
      rst = 1'b0;
      exp_pc = 16'h0000;
      #1;
      vectors++;
      if (pc_op !== OP_RESET) begin
         miscompares++;
         $display("FAIL reset_release_op: op=%b expected 00", pc_op);
      end
   endtask

   task automatic test_sequential();
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      test_reset();
      deliver(0, 0, 8'h00, 0, 16'h0);
      deliver(0, 0, 8'h00, 0, 16'h0);
      vectors++;
      if (exp_pc !== 16'd4) begin
         miscompares++;
         $display("FAIL seq_pc: model pc=%h expected 0004", exp_pc);
      end
   endtask

   task automatic test_backpressure();
      deliver(3, 0, 8'h00, 0, 16'h0);
   endtask

   task automatic test_jump();
      test_reset();
      deliver(0, 1, 8'h02, 0, 16'h0);
      vectors++;
      if (exp_pc !== 16'd6) begin
         miscompares++;
         $display("FAIL jump_target: model pc=%h expected 0006", exp_pc);
      end
      deliver(1, 0, 8'h00, 0, 16'h0);
   endtask

   task automatic test_wrap();
      deliver(0, 0, 8'h00, 1, 16'hFFFE);
      deliver(0, 0, 8'h00, 0, 16'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         deliver($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 8'($signed($urandom_range(0, 16)) - 8), 0, 16'h0);
   endtask

   task automatic test_reset_mid_fetch();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (instr_valid !== 1'b0 || instr !== 16'h0000 || pc_op !== OP_RESET || mem_own !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: valid=%b instr=%h op=%b own=%b expected 0 0000 00 0",
                  instr_valid, instr, pc_op, mem_own);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_pc = 16'h0000;
      deliver(0, 0, 8'h00, 0, 16'h0);
   endtask

   task automatic test_halt();
      mem[2] = 8'hFF;
      mem[3] = 8'hFF;
      test_reset();
      deliver(0, 0, 8'h00, 0, 16'h0);
`ifdef IFETCH_HALT_EN
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_valid: valid=%b expected 0", instr_valid);
         end
      end
      vectors++;
      if (halted !== 1'b1 || mem_own !== 1'b0 || pc_op !== OP_NOTHING || pc_addr !== 16'd4) begin
         miscompares++;
         $display("FAIL halt_state: halted=%b own=%b op=%b pc=%h expected 1 0 01 0004",
                  halted, mem_own, pc_op, pc_addr);
      end
`else
      deliver(0, 0, 8'h00, 0, 16'h0);
      vectors++;
      if (halted !== 1'b0 || exp_word !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL no_halt: halted=%b word=%h expected 0 FFFF", halted, exp_word);
      end
`endif
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 254));
      test_sequential();
      test_backpressure();
      test_jump();
      test_wrap();
      test_random();
      test_reset_mid_fetch();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
